// File: rtl/counter_pkg.sv
// Shared definitions for the BCD display counter: converter state encoding,
// shift-and-add-3 constants and the digit-count helper used at elaboration.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // A nibble at or above this value would overflow past 9 after doubling.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Number of decimal digits needed to show value (at least one).
  function automatic int digits_required(input int unsigned value);
    int          n;
    int unsigned v;
    n = 1;
    v = value;
    for (int i = 0; i < 10; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Iterative shift-and-add-3 binary-to-BCD converter. One bit per cycle;
// the result is published only once all WIDTH shifts are complete.
//
// Handshake: start is sampled only in IDLE; valid is a one-cycle pulse that
// coincides with bcd taking the new value; busy is high in SHIFT and DONE,
// i.e. whenever a start would be ignored.
module bcd_seq_conv
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                valid,
  output logic                busy,
  output conv_state_e         state
);

  localparam int BW  = 4 * DIGITS;
  localparam int SRW = BW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  conv_state_e       state_q, state_d;
  logic [SRW-1:0]    sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              valid_q, valid_d;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the doubling shift.
  function automatic logic [SRW-1:0] adjust(input logic [SRW-1:0] v);
    logic [SRW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[WIDTH+4*i +: 4] >= BCD_ADJ_THRESH)
        r[WIDTH+4*i +: 4] = r[WIDTH+4*i +: 4] + BCD_ADJ_ADD;
    end
    return r;
  endfunction

  // Next-state and datapath for the converter FSM.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = {{BW{1'b0}}, bin};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = adjust(sr_q) << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = sr_q[SRW-1 -: BW];
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Converter state registers; reset drops any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign busy  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign state = state_q;

endmodule

// File: rtl/mod_counter_bcd.sv
// Loadable up/down counter with programmable terminal value, wrap/saturate
// boundary handling and a terminal-count flag, plus a BCD converter that
// follows the count for the 7-segment display path.
module mod_counter_bcd
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MAX    = 2**WIDTH - 1,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_n,
  input  logic [WIDTH-1:0]    d,
  input  logic                en,
  input  logic                up,
  input  logic                wrap,
  output logic [WIDTH-1:0]    q,
  output logic                tc,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid,
  output logic                busy,
  output conv_state_e         conv_state
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("mod_counter_bcd: WIDTH must be in 2..16");
  end
  if (MAX < 1 || MAX > 2**WIDTH - 1) begin : g_bad_max
    $error("mod_counter_bcd: MAX must be in 1..2**WIDTH-1");
  end
  if (digits_required(MAX) > DIGITS) begin : g_bad_digits
    $error("mod_counter_bcd: DIGITS too small to show MAX");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             conv_busy;
  logic             start;

  // Count update: load (clamped to MAX) beats count enable.
  always_comb begin
    q_d = q_q;
    if (!load_n) begin
      q_d = (d > MAX_V) ? MAX_V : d;
    end else if (en) begin
      if (up) q_d = (q_q == MAX_V) ? (wrap ? '0 : MAX_V) : q_q + WIDTH'(1);
      else    q_d = (q_q == '0)    ? (wrap ? MAX_V : '0) : q_q - WIDTH'(1);
    end
  end

  // A new conversion starts whenever the converter is idle and the count has
  // moved away from the last converted value; snap records that value.
  assign start  = !conv_busy && (q_q != snap_q);
  assign snap_d = start ? q_q : snap_q;

  // Count and snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      snap_q <= '0;
    end else begin
      q_q    <= q_d;
      snap_q <= snap_d;
    end
  end

  assign tc = load_n & en & ((up & (q_q == MAX_V)) | (~up & (q_q == '0)));
  assign q  = q_q;

  bcd_seq_conv #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (q_q),
    .bcd   (bcd),
    .valid (bcd_valid),
    .busy  (conv_busy),
    .state (conv_state)
  );

  assign busy = conv_busy;

endmodule

// File: tb/tb_mod_counter_bcd.sv
// Directed bench for mod_counter_bcd: one full-range instance (MAX=255) and
// one clamped instance (MAX=199) driven by the same inputs.
module tb_mod_counter_bcd;
  import counter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        load_n;
  logic [7:0]  d;
  logic        en;
  logic        up;
  logic        wrap;

  logic [7:0]  q_a, q_b;
  logic        tc_a, tc_b;
  logic [11:0] bcd_a, bcd_b;
  logic        val_a, val_b;
  logic        busy_a, busy_b;
  conv_state_e st_a, st_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_counter_bcd u_dut (
    .clk(clk), .rst_n(rst_n), .load_n(load_n), .d(d), .en(en), .up(up),
    .wrap(wrap), .q(q_a), .tc(tc_a), .bcd(bcd_a), .bcd_valid(val_a),
    .busy(busy_a), .conv_state(st_a)
  );

  mod_counter_bcd #(.WIDTH(8), .MAX(199), .DIGITS(3)) u_dut199 (
    .clk(clk), .rst_n(rst_n), .load_n(load_n), .d(d), .en(en), .up(up),
    .wrap(wrap), .q(q_b), .tc(tc_b), .bcd(bcd_b), .bcd_valid(val_b),
    .busy(busy_b), .conv_state(st_b)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic all_bcd(input logic [11:0] v);
    logic [11:0] t;
    t = v;
    return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd9) && (t[11:8] <= 4'd9);
  endfunction

  initial begin
    logic [7:0] seq_q [4];
    logic       seq_tc[4];
    logic [11:0] got;

    rst_n = 1'b0; load_n = 1'b1; d = '0; en = 1'b0; up = 1'b1; wrap = 1'b1;

    // Reset state
    #12;
    chk("rst_q", q_a, 0);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_state", st_a, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    steps(3);
    chk("post_rst_busy", busy_a, 0);

    // Full-range wrap count, tc only at 255
    en = 1'b1; up = 1'b1; wrap = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) begin
      if (q_a !== 8'(i) || tc_a !== (i == 255)) begin
        chk($sformatf("cnt_q_%0d", i), q_a, 8'(i));
        chk($sformatf("cnt_tc_%0d", i), tc_a, (i == 255));
      end
      step();
    end
    n_assert++;  // the 256-step sweep counts as one comparison when clean
    chk("wrap_q", q_a, 0);
    en = 1'b0;
    steps(30);
    chk("wrap_bcd", bcd_a, 12'h000);
    chk("clamp_inst_q", q_b, 8'd56);
    chk("clamp_inst_bcd", bcd_b, 12'h056);

    // Load above MAX clamps; conversion latency
    d = 8'd200; load_n = 1'b0;
    step();
    load_n = 1'b1;
    chk("clamp_q", q_b, 8'd199);
    chk("noclamp_q", q_a, 8'd200);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("lat_valid_k%0d", k), val_b, (k == 10));
    end
    chk("clamp_bcd", bcd_b, 12'h199);
    chk("noclamp_bcd", bcd_a, 12'h200);
    step();
    chk("valid_one_cycle", val_b, 0);

    // Saturating down-count at zero
    up = 1'b0; wrap = 1'b0; d = 8'd1; load_n = 1'b0;
    step();
    load_n = 1'b1;
    seq_q[0] = 8'd1; seq_q[1] = 8'd0; seq_q[2] = 8'd0; seq_q[3] = 8'd0;
    seq_tc[0] = 1'b0; seq_tc[1] = 1'b1; seq_tc[2] = 1'b1; seq_tc[3] = 1'b1;
    en = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sat_q_%0d", i), q_a, seq_q[i]);
      chk($sformatf("sat_tc_%0d", i), tc_a, seq_tc[i]);
      step();
    end
    en = 1'b0;
    #1;
    chk("sat_q_end", q_a, 0);
    chk("sat_tc_en_low", tc_a, 0);

    // Load and enable together: load wins
    up = 1'b1; wrap = 1'b1; d = 8'd42; load_n = 1'b0; en = 1'b1;
    #1;
    chk("load_tc_masked", tc_a, 0);
    step();
    load_n = 1'b1; en = 1'b0;
    chk("load_pri_q", q_a, 8'd42);
    steps(30);
    chk("load_pri_bcd", bcd_a, 12'h042);

    // Count changes during a conversion: 123 then 130
    d = 8'd123; load_n = 1'b0;
    step();
    load_n = 1'b1;
    exp_q.push_back(12'h123);
    exp_q.push_back(12'h130);
    for (int k = 1; k <= 25; k++) begin
      en = (k <= 7);
      step();
      chk($sformatf("mid_valid_k%0d", k), val_a, (k == 10 || k == 20));
      chk($sformatf("mid_nibbles_k%0d", k), all_bcd(bcd_a), 1);
      if (val_a && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk($sformatf("mid_bcd_k%0d", k), bcd_a, got);
      end
    end
    en = 1'b0;
    chk("mid_q", q_a, 8'd130);
    chk("mid_pending", exp_q.size(), 0);

    // Reset in the middle of a conversion
    d = 8'd77; load_n = 1'b0;
    step();
    load_n = 1'b1;
    steps(3);
    chk("pre_rst_busy", busy_a, 1);
    chk("pre_rst_state", st_a, ST_SHIFT);
    rst_n = 1'b0;
    #1;
    chk("arst_q", q_a, 0);
    chk("arst_bcd", bcd_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_valid", val_a, 0);
    steps(2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("post_arst_valid_%0d", k), val_a, 0);
      chk($sformatf("post_arst_busy_%0d", k), busy_a, 0);
    end
    chk("post_arst_bcd", bcd_a, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
